// File: rtl/rts_signature_checker_if.sv
// Handshake/bus bundle for the RTS signature checker: stimulus side (master) and checker side (slave).
// The diagnostic syndrome signals exist only when DIAG_SYNDROME_EN is defined.
`timescale 1ns/1ps
interface rts_signature_checker_if #(
  parameter int MISR_SIZE = 24,
  parameter int SISA_SIZE = 16,
  parameter int CFG_AW    = 2,
  parameter int CNT_W     = 8
);
  logic                          sessionStart;
  logic                          gldWrEn;
  logic [CFG_AW-1:0]             gldWrAddr;
  logic [MISR_SIZE+SISA_SIZE-1:0] gldWrData;
  logic                          done;
  logic [MISR_SIZE-1:0]          MISR_Out;
  logic [SISA_SIZE-1:0]          SISA_Out;
  logic                          resultAck;
  logic                          resultValid;
  logic                          resultPass;
  logic [CFG_AW-1:0]             cfgIdx;
  logic [CNT_W-1:0]              passCnt;
  logic [CNT_W-1:0]              failCnt;
  logic                          busy;
  logic                          allDone;
  logic                          overrun;
`ifdef DIAG_SYNDROME_EN
  logic [MISR_SIZE+SISA_SIZE-1:0] errSyndrome;
  logic [CFG_AW-1:0]             firstFailIdx;
`endif

  modport master (
    output sessionStart, gldWrEn, gldWrAddr, gldWrData, done, MISR_Out, SISA_Out, resultAck,
    input  resultValid, resultPass, cfgIdx, passCnt, failCnt, busy, allDone, overrun
`ifdef DIAG_SYNDROME_EN
    , input errSyndrome, firstFailIdx
`endif
  );

  modport slave (
    input  sessionStart, gldWrEn, gldWrAddr, gldWrData, done, MISR_Out, SISA_Out, resultAck,
    output resultValid, resultPass, cfgIdx, passCnt, failCnt, busy, allDone, overrun
`ifdef DIAG_SYNDROME_EN
    , output errSyndrome, firstFailIdx
`endif
  );
endinterface

// File: rtl/rts_signature_checker.sv
// Far-end BIST response evaluator: compares captured MISR/SISA signatures against a golden dictionary.
// Optional DIAG_SYNDROME_EN adds a frozen first-fail syndrome and failing configuration index.
`timescale 1ns/1ps
module rts_signature_checker #(
  parameter int MISR_SIZE = 24,
  parameter int SISA_SIZE = 16,
  parameter int NUM_CFG   = 4,
  parameter int CFG_AW    = 2,
  parameter int CNT_W     = 8
) (
  input logic clk,
  input logic masterRstN,
  rts_signature_checker_if.slave bus
);
  localparam int SIG_W = MISR_SIZE + SISA_SIZE;

  typedef enum logic [2:0] {IDLE, WAIT_DONE, COMPARE, REPORT, FINISHED} state_t;

  state_t             state_q, state_d;
  logic               done_q;
  logic [SIG_W-1:0]   capture;
  logic [SIG_W-1:0]   gld [NUM_CFG];
  logic [SIG_W-1:0]   gold;
  logic               done_rise, match, last_cfg;
  logic               result_valid, result_pass, all_done, overrun;
  logic [CFG_AW-1:0]  cfg_idx;
  logic [CNT_W-1:0]   pass_cnt, fail_cnt;

  assign done_rise = bus.done & ~done_q;
  assign gold      = gld[cfg_idx];
  assign match     = (capture == gold);
  assign last_cfg  = (int'(cfg_idx) == NUM_CFG - 1);

  always_ff @(posedge clk or negedge masterRstN) begin
    if (!masterRstN) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.sessionStart) state_d = WAIT_DONE;
    else begin
      case (state_q)
        WAIT_DONE: if (done_rise) state_d = COMPARE;
        COMPARE:   state_d = REPORT;
        REPORT:    if (bus.resultAck) state_d = last_cfg ? FINISHED : WAIT_DONE;
        default:   state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge masterRstN) begin
    if (!masterRstN) begin
      done_q       <= 1'b0;
      capture      <= '0;
      for (int i = 0; i < NUM_CFG; i++) gld[i] <= '0;
      result_valid <= 1'b0;
      result_pass  <= 1'b0;
      all_done     <= 1'b0;
      overrun      <= 1'b0;
      cfg_idx      <= '0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
    end else begin
      done_q <= bus.done;
      // Writes land after the edge, so a same-cycle COMPARE still sees the old entry.
      if (bus.gldWrEn && int'(bus.gldWrAddr) < NUM_CFG) gld[bus.gldWrAddr] <= bus.gldWrData;
      if (bus.sessionStart) begin
        result_valid <= 1'b0;
        result_pass  <= 1'b0;
        all_done     <= 1'b0;
        overrun      <= 1'b0;
        cfg_idx      <= '0;
        pass_cnt     <= '0;
        fail_cnt     <= '0;
      end else begin
        case (state_q)
          WAIT_DONE: if (done_rise) capture <= {bus.MISR_Out, bus.SISA_Out};
          COMPARE: begin
            result_valid <= 1'b1;
            result_pass  <= match;
            if (match) pass_cnt <= (&pass_cnt) ? pass_cnt : pass_cnt + 1'b1;
            else       fail_cnt <= (&fail_cnt) ? fail_cnt : fail_cnt + 1'b1;
            if (done_rise) overrun <= 1'b1;
          end
          REPORT: begin
            if (done_rise) overrun <= 1'b1;
            if (bus.resultAck) begin
              result_valid <= 1'b0;
              if (last_cfg) all_done <= 1'b1;
              else          cfg_idx  <= cfg_idx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DIAG_SYNDROME_EN
  logic [SIG_W-1:0]  err_syndrome;
  logic [CFG_AW-1:0] first_fail_idx;

  // fail_cnt still zero in COMPARE means this is the session's first mismatch.
  always_ff @(posedge clk or negedge masterRstN) begin
    if (!masterRstN) begin
      err_syndrome   <= '0;
      first_fail_idx <= '0;
    end else if (bus.sessionStart) begin
      err_syndrome   <= '0;
      first_fail_idx <= '0;
    end else if (state_q == COMPARE && !match && fail_cnt == '0) begin
      err_syndrome   <= capture ^ gold;
      first_fail_idx <= cfg_idx;
    end
  end

  assign bus.errSyndrome  = err_syndrome;
  assign bus.firstFailIdx = first_fail_idx;
`endif

  assign bus.resultValid = result_valid;
  assign bus.resultPass  = result_pass;
  assign bus.cfgIdx      = cfg_idx;
  assign bus.passCnt     = pass_cnt;
  assign bus.failCnt     = fail_cnt;
  assign bus.busy        = (state_q == WAIT_DONE) || (state_q == COMPARE) || (state_q == REPORT);
  assign bus.allDone     = all_done;
  assign bus.overrun     = overrun;
endmodule
